// File: rtl/calc_pkg.sv
// Shared types and constants for the UART calculator command engine.
// The optional '%' operator is enabled by defining CALC_MOD_EN.
package calc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      OP1,
      OP2,
      EXEC,
      DIV,
      SYNC,
      DONE
   } calc_state_e;

   localparam logic [2:0] ERR_OK       = 3'd0;
   localparam logic [2:0] ERR_BAD_CHAR = 3'd1;
   localparam logic [2:0] ERR_OPND     = 3'd2;
   localparam logic [2:0] ERR_EMPTY    = 3'd3;
   localparam logic [2:0] ERR_DIV0     = 3'd4;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_STAR  = 8'h2A;
   localparam logic [7:0] ASCII_SLASH = 8'h2F;
   localparam logic [7:0] ASCII_PCT   = 8'h25;
   localparam logic [7:0] ASCII_EQ    = 8'h3D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SP    = 8'h20;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_0) && (b <= ASCII_9);
   endfunction

   function automatic logic is_term(input logic [7:0] b);
      return (b == ASCII_EQ) || (b == ASCII_CR) || (b == ASCII_LF);
   endfunction

   function automatic logic is_op(input logic [7:0] b);
`ifdef CALC_MOD_EN
      return (b == ASCII_PLUS) || (b == ASCII_MINUS) || (b == ASCII_STAR) ||
             (b == ASCII_SLASH) || (b == ASCII_PCT);
`else
      return (b == ASCII_PLUS) || (b == ASCII_MINUS) || (b == ASCII_STAR) ||
             (b == ASCII_SLASH);
`endif
   endfunction

endpackage

// File: rtl/calc_divider.sv
// Iterative restoring divider: one quotient bit per cycle, DATA_W cycles from
// start to the done pulse. The first step is taken on the start edge itself.
module calc_divider #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              done
);

   localparam int CW = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] dvs_q;
   logic [CW-1:0]     cnt;

   function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] r,
                                                     input logic [DATA_W-1:0] q,
                                                     input logic [DATA_W-1:0] d);
      logic [DATA_W:0] sh;
      logic [DATA_W:0] trial;
      sh    = {r, q[DATA_W-1]};
      trial = sh - {1'b0, d};
      // A set MSB means the trial went negative: restore the shifted remainder.
      if (trial[DATA_W])
         return {sh[DATA_W-1:0], q[DATA_W-2:0], 1'b0};
      else
         return {trial[DATA_W-1:0], q[DATA_W-2:0], 1'b1};
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            {rem_q, quo_q} <= div_step('0, dividend, divisor);
            dvs_q          <= divisor;
            cnt            <= CW'(DATA_W - 1);
         end else if (cnt != '0) begin
            {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
            cnt            <= cnt - CW'(1);
            if (cnt == CW'(1))
               done <= 1'b1;
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/calc_cmd_engine.sv
// ASCII "<num><op><num>=" parser and executor between uart_rx and spi_lcd.
// Define CALC_MOD_EN to accept '%' (remainder through the shared divider).
//
// state | meaning
// IDLE  | waiting for the first digit of operand 1
// OP1   | accumulating operand 1, waiting for operator
// OP2   | accumulating operand 2, waiting for terminator
// EXEC  | one-cycle execute of + - * and divide-by-zero check
// DIV   | divider running, input bytes dropped
// SYNC  | error seen, discarding bytes through the next terminator
// DONE  | done pulse; a byte arriving here starts the next expression
module calc_cmd_engine
   import calc_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int MAX_DIGITS = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] operand1,
   output logic [DATA_W-1:0] operand2,
   output logic [7:0]        operator,
   output logic [DATA_W-1:0] result,
   output logic              neg,
   output logic              ovf,
   output logic [2:0]        err_code,
   output logic              done,
   output logic              busy,
   output logic              rx_drop
);

   localparam int AW = DATA_W + 4;
   localparam int PW = 2 * DATA_W;
   localparam int NW = $clog2(MAX_DIGITS + 1);

   calc_state_e       state;
   logic [AW-1:0]     acc;
   logic [NW-1:0]     ndig;
   logic [2:0]        err_r;

   logic [AW-1:0]     acc_next;
   logic              acc_ovf;
   logic [DATA_W:0]   sum;
   logic [PW-1:0]     prod;
   logic              div_op;
   logic              div_start;
   logic              div_done;
   logic [DATA_W-1:0] div_quo;
   logic [DATA_W-1:0] div_res;

   // acc*10 + digit; the 4 spare bits hold any single-step overshoot.
   assign acc_next  = (acc << 3) + (acc << 1) + AW'(rx_data[3:0]);
   assign acc_ovf   = (ndig == NW'(MAX_DIGITS)) || (|acc_next[AW-1:DATA_W]);
   assign sum       = {1'b0, operand1} + {1'b0, operand2};
   assign prod      = PW'(operand1) * PW'(operand2);
   assign div_start = (state == EXEC) && div_op && (operand2 != '0);
   assign rx_drop   = rx_valid & busy;

`ifdef CALC_MOD_EN
   logic [DATA_W-1:0] div_rem;

   assign div_op  = (operator == ASCII_SLASH) || (operator == ASCII_PCT);
   assign div_res = (operator == ASCII_PCT) ? div_rem : div_quo;

   calc_divider #(.DATA_W(DATA_W)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .dividend  (operand1),
      .divisor   (operand2),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );
`else
   assign div_op  = (operator == ASCII_SLASH);
   assign div_res = div_quo;

   calc_divider #(.DATA_W(DATA_W)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .dividend  (operand1),
      .divisor   (operand2),
      .quotient  (div_quo),
      .remainder (),
      .done      (div_done)
   );
`endif

   task automatic finish(input logic [DATA_W-1:0] r, input logic n, input logic o,
                         input logic [2:0] e);
      result   <= r;
      neg      <= n;
      ovf      <= o;
      err_code <= e;
      done     <= 1'b1;
      busy     <= 1'b0;
      state    <= DONE;
   endtask

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         acc      <= '0;
         ndig     <= '0;
         err_r    <= ERR_OK;
         operand1 <= '0;
         operand2 <= '0;
         operator <= '0;
         result   <= '0;
         neg      <= 1'b0;
         ovf      <= 1'b0;
         err_code <= ERR_OK;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (rx_valid && rx_data != ASCII_SP) begin
                  if (is_digit(rx_data)) begin
                     acc   <= AW'(rx_data[3:0]);
                     ndig  <= NW'(1);
                     state <= OP1;
                  end else if (is_term(rx_data)) begin
                     finish('0, 1'b0, 1'b0, ERR_EMPTY);
                  end else begin
                     err_r <= is_op(rx_data) ? ERR_EMPTY : ERR_BAD_CHAR;
                     state <= SYNC;
                  end
               end
            end
            OP1, OP2: begin
               if (rx_valid && rx_data != ASCII_SP) begin
                  if (is_digit(rx_data)) begin
                     if (acc_ovf) begin
                        err_r <= ERR_OPND;
                        state <= SYNC;
                     end else begin
                        acc  <= acc_next;
                        ndig <= ndig + NW'(1);
                     end
                  end else if (is_op(rx_data) && state == OP1) begin
                     operand1 <= acc[DATA_W-1:0];
                     operator <= rx_data;
                     acc      <= '0;
                     ndig     <= '0;
                     state    <= OP2;
                  end else if (is_term(rx_data)) begin
                     // The terminator already closes the expression, so an
                     // empty operand reports straight away instead of via SYNC.
                     if (state == OP2 && ndig != '0) begin
                        operand2 <= acc[DATA_W-1:0];
                        busy     <= 1'b1;
                        state    <= EXEC;
                     end else begin
                        finish('0, 1'b0, 1'b0, ERR_EMPTY);
                     end
                  end else begin
                     err_r <= ERR_BAD_CHAR;
                     state <= SYNC;
                  end
               end
            end
            EXEC: begin
               case (operator)
                  ASCII_PLUS:  finish(sum[DATA_W-1:0], 1'b0, sum[DATA_W], ERR_OK);
                  ASCII_MINUS: begin
                     if (operand1 >= operand2)
                        finish(operand1 - operand2, 1'b0, 1'b0, ERR_OK);
                     else
                        finish(operand2 - operand1, 1'b1, 1'b0, ERR_OK);
                  end
                  ASCII_STAR:  finish(prod[DATA_W-1:0], 1'b0, |prod[PW-1:DATA_W], ERR_OK);
                  default: begin
                     if (operand2 == '0)
                        finish('0, 1'b0, 1'b0, ERR_DIV0);
                     else
                        state <= DIV;
                  end
               endcase
            end
            DIV: begin
               if (div_done)
                  finish(div_res, 1'b0, 1'b0, ERR_OK);
            end
            SYNC: begin
               if (rx_valid && is_term(rx_data))
                  finish('0, 1'b0, 1'b0, err_r);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
